// File: rtl/tt_um_syndrome_check_pkg.sv
// Shared geometry and FSM encoding for the syndrome checker and the shift network
// that feeds it.
package tt_um_syndrome_check_pkg;

  localparam int unsigned LiftingFactor = 4;
  localparam int unsigned NumRows       = 4;
  // Wide enough to hold NumRows*LiftingFactor, the largest possible weight.
  localparam int unsigned WeightWidth   = $clog2(NumRows * LiftingFactor + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/tt_um_popcount.sv
// Combinational population count of a Width-bit vector.
module tt_um_popcount #(
  parameter int unsigned Width      = 4,
  parameter int unsigned CountWidth = $clog2(Width + 1)
) (
  input  logic [Width-1:0]      data,
  output logic [CountWidth-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < Width; i++) begin
      count = count + CountWidth'(data[i]);
    end
  end

endmodule

// File: rtl/tt_um_syndrome_check.sv
// Accumulates shifted hard-decision blocks per check row and reports the per-row
// syndrome status and the total number of unsatisfied checks.
module tt_um_syndrome_check
  import tt_um_syndrome_check_pkg::*;
#(
  parameter int unsigned LiftingFactor = tt_um_syndrome_check_pkg::LiftingFactor,
  parameter int unsigned NumRows       = tt_um_syndrome_check_pkg::NumRows,
  parameter int unsigned WeightWidth   = tt_um_syndrome_check_pkg::WeightWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LiftingFactor-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_pass,
  output logic [NumRows-1:0]       out_fail_rows,
  output logic [WeightWidth-1:0]   out_weight,
  output logic                     busy
);

  localparam int unsigned RowIdxWidth = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned PopWidth    = $clog2(LiftingFactor + 1);

  state_e state_q, state_d;

  logic [LiftingFactor-1:0] acc_q, acc_d;
  logic [RowIdxWidth-1:0]   row_idx_q, row_idx_d;
  logic [NumRows-1:0]       fail_rows_q, fail_rows_d;
  logic [WeightWidth-1:0]   weight_q, weight_d;

  logic [LiftingFactor-1:0] syn;
  logic [PopWidth-1:0]      syn_pop;
  logic                     accept;
  logic                     last_row;

  // A start in ACCUM restarts the codeword, so the concurrent beat is dropped.
  assign accept   = (state_q == StAccum) && in_valid && !start;
  assign syn      = acc_q ^ in_data;
  assign last_row = (row_idx_q == RowIdxWidth'(NumRows - 1));

  tt_um_popcount #(
    .Width     (LiftingFactor),
    .CountWidth(PopWidth)
  ) u_popcount (
    .data (syn),
    .count(syn_pop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StAccum;
      end
      StAccum: begin
        if (accept && in_last && last_row) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == StAccum);
    out_valid     = (state_q == StDone);
    busy          = (state_q != StIdle);
    out_pass      = (state_q == StDone) && (weight_q == '0);
    out_fail_rows = (state_q == StDone) ? fail_rows_q : '0;
    out_weight    = (state_q == StDone) ? weight_q : '0;
  end

  always_comb begin
    acc_d       = acc_q;
    row_idx_d   = row_idx_q;
    fail_rows_d = fail_rows_q;
    weight_d    = weight_q;
    if (start && (state_q != StDone)) begin
      acc_d       = '0;
      row_idx_d   = '0;
      fail_rows_d = '0;
      weight_d    = '0;
    end else if (accept) begin
      if (in_last) begin
        acc_d                  = '0;
        fail_rows_d[row_idx_q] = |syn;
        weight_d               = weight_q + WeightWidth'(syn_pop);
        // Hold on the final row so the index never wraps within a codeword.
        if (!last_row) row_idx_d = row_idx_q + 1'b1;
      end else begin
        acc_d = syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      row_idx_q   <= '0;
      fail_rows_q <= '0;
      weight_q    <= '0;
    end else begin
      acc_q       <= acc_d;
      row_idx_q   <= row_idx_d;
      fail_rows_q <= fail_rows_d;
      weight_q    <= weight_d;
    end
  end

endmodule

// File: tb/tb_tt_um_syndrome_check.sv
// Directed bench for tt_um_syndrome_check: codeword scenarios with hand-computed results.
module tb_tt_um_syndrome_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_pass;
  logic [3:0] out_fail_rows;
  logic [4:0] out_weight;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tt_um_syndrome_check dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pass     (out_pass),
    .out_fail_rows(out_fail_rows),
    .out_weight   (out_weight),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data  = 4'hF;
    in_last  = 1'b1;
    tick();
    in_data  = 4'h0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic pass, input logic [3:0] rows,
                              input logic [4:0] weight);
    check({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
    check({tag, "_pass"}, 32'(out_pass), 32'(pass));
    check({tag, "_rows"}, 32'(out_fail_rows), 32'(rows));
    check({tag, "_weight"}, 32'(out_weight), 32'(weight));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1'b0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(1'b0));
    check({tag, "_pass"}, 32'(out_pass), 32'(1'b0));
    check({tag, "_rows"}, 32'(out_fail_rows), 32'(4'h0));
    check({tag, "_weight"}, 32'(out_weight), 32'(5'h0));
    check({tag, "_busy"}, 32'(busy), 32'(1'b0));
  endtask

  task automatic clean_codeword();
    beat(4'b0101, 1'b0); beat(4'b0101, 1'b1);
    beat(4'b1111, 1'b0); beat(4'b1111, 1'b1);
    beat(4'b0011, 1'b0); beat(4'b0011, 1'b1);
    beat(4'b1000, 1'b0);
    check("pre_last_valid", 32'(out_valid), 32'(1'b0));
    beat(4'b1000, 1'b1);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle("reset");

    // Clean codeword
    do_start();
    check("start_busy", 32'(busy), 32'(1'b1));
    check("start_in_ready", 32'(in_ready), 32'(1'b1));
    clean_codeword();
    check_result("clean", 1'b1, 4'b0000, 5'd0);
    consume();
    check("clean_back_idle_busy", 32'(busy), 32'(1'b0));
    check("clean_back_idle_valid", 32'(out_valid), 32'(1'b0));

    // Errored codeword with backpressure; start and in_valid must be ignored in DONE
    do_start();
    beat(4'b0001, 1'b1);
    beat(4'b0000, 1'b0); beat(4'b0000, 1'b1);
    beat(4'b1100, 1'b0); beat(4'b0100, 1'b1);
    beat(4'b1111, 1'b1);
    check_result("err", 1'b0, 4'b1101, 5'd6);
    for (int i = 0; i < 5; i++) begin
      start    = (i == 2);
      in_valid = 1'b1;
      in_data  = 4'b1111;
      in_last  = 1'b1;
      tick();
      check_result("hold", 1'b0, 4'b1101, 5'd6);
      check("hold_in_ready", 32'(in_ready), 32'(1'b0));
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0;
    consume();
    check("hold_release_busy", 32'(busy), 32'(1'b0));
    check("hold_release_valid", 32'(out_valid), 32'(1'b0));

    // Abort after two rows; the beat presented alongside start is discarded
    do_start();
    beat(4'b0011, 1'b1);
    beat(4'b0101, 1'b0); beat(4'b0101, 1'b1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0;
    check("abort_busy", 32'(busy), 32'(1'b1));
    beat(4'b0101, 1'b0); beat(4'b0101, 1'b1);
    beat(4'b1111, 1'b0); beat(4'b1111, 1'b1);
    beat(4'b0011, 1'b0); beat(4'b0011, 1'b1);
    check("abort_row3_not_done", 32'(out_valid), 32'(1'b0));
    beat(4'b1000, 1'b0); beat(4'b1000, 1'b1);
    check_result("abort", 1'b1, 4'b0000, 5'd0);
    consume();

    // Reset mid-ACCUM, then beats without start are never accepted
    do_start();
    beat(4'b1010, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    for (int i = 0; i < 4; i++) beat(4'b1111, 1'b1);
    check_idle("nostart");

    // Gapped rows: invalid cycles carry garbage that must not be XORed
    do_start();
    beat(4'b0110, 1'b0); gap(); beat(4'b0110, 1'b1);
    beat(4'b1010, 1'b1);
    beat(4'b1000, 1'b0); gap(); gap(); beat(4'b0001, 1'b1);
    gap();
    beat(4'b0000, 1'b1);
    check_result("gaps", 1'b0, 4'b0110, 5'd4);
    consume();

    // Same codeword without gaps
    do_start();
    beat(4'b0110, 1'b0); beat(4'b0110, 1'b1);
    beat(4'b1010, 1'b1);
    beat(4'b1000, 1'b0); beat(4'b0001, 1'b1);
    beat(4'b0000, 1'b1);
    check_result("nogaps", 1'b0, 4'b0110, 5'd4);
    consume();
    check("final_busy", 32'(busy), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_syndrome_check.md
TT_UM_SYNDROME_CHECK -- requirements
Module: tt_um_syndrome_check

Interface
REQ-001 Parameter LiftingFactor, default 4, SHALL set the lane count per beat; this matches the shift-network output width.
REQ-002 Parameter NumRows, default 4, SHALL set the number of check-row blocks per codeword.
REQ-003 Parameter WeightWidth, default 5, SHALL hold the value NumRows*LiftingFactor.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single rising-edge clock.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port start, input, 1 bit: begin a new codeword check.
REQ-008 Port in_valid, input, 1 bit: in_data is valid.
REQ-009 Port in_ready, output, 1 bit: the block accepts a beat.
REQ-010 Port in_data, input, LiftingFactor bits: shifted hard-decision block from the shift network.
REQ-011 Port in_last, input, 1 bit: the current beat is the final block of the current check row.
REQ-012 Port out_valid, output, 1 bit: the result is available.
REQ-013 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 Port out_pass, output, 1 bit: all syndrome bits are zero.
REQ-015 Port out_fail_rows, output, NumRows bits: bit r is set when row r has a nonzero syndrome.
REQ-016 Port out_weight, output, WeightWidth bits: total count of unsatisfied checks.
REQ-017 Port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-019 IDLE: in_ready=0 and out_valid=0; start=1 SHALL move the FSM to ACCUM next cycle and clear the accumulator, row index, fail_rows and weight.
REQ-020 ACCUM: in_ready=1; each accepted beat (in_valid and in_ready) SHALL update acc to acc XOR in_data.
REQ-021 On an accepted beat with in_last=1, the row syndrome s = acc XOR in_data SHALL be computed in the same cycle.
REQ-022 For that beat, the block SHALL register fail_rows[row_idx] = OR-reduce(s), add popcount(s) to weight, set acc to 0 and increment row_idx.
REQ-023 An in_last beat with row_idx = NumRows-1 SHALL move the FSM to DONE next cycle, with no further beats accepted.
REQ-024 DONE: out_valid=1, and out_pass = (weight==0), out_fail_rows and out_weight SHALL be held stable until the handshake out_valid and out_ready.
REQ-025 After the handshake the FSM SHALL return to IDLE next cycle.
REQ-026 Latency: out_valid SHALL assert exactly one cycle after the final in_last beat is accepted.
REQ-027 If start=1 in ACCUM, the block SHALL abort and restart: acc, row_idx, fail_rows and weight cleared, FSM remains in ACCUM, and any beat presented in that cycle is discarded.
REQ-028 start SHALL be ignored in DONE; the result must be consumed first.
REQ-029 in_valid SHALL be ignored while in_ready=0.
REQ-030 out_ready SHALL be ignored while out_valid=0.
REQ-031 A row with a single beat (in_last on its first beat) SHALL be legal; then s = in_data.
REQ-032 Weight arithmetic is unsigned and SHALL not overflow, since the maximum is NumRows*LiftingFactor = 16 and fits 5 bits.
REQ-033 row_idx SHALL never wrap inside a codeword; its width is ceil(log2(NumRows)).

Reset
REQ-034 While rst=1 at a clock edge, the FSM SHALL go to IDLE and acc, row_idx, fail_rows and weight SHALL go to 0.
REQ-035 Outputs during reset SHALL be: in_ready=0, out_valid=0, out_pass=0, out_fail_rows=0, out_weight=0, busy=0.
REQ-036 rst SHALL take priority over start and all handshakes, including mid-ACCUM and mid-DONE; the pending result is discarded.

Structure
REQ-037 A shared package SHALL hold LiftingFactor, NumRows, WeightWidth and the FSM state encoding, so that this block and the shift network share them.
REQ-038 One sub-module, tt_um_popcount, SHALL implement the combinational LiftingFactor-bit population count.
REQ-039 No other hierarchy is permitted.

Verification
REQ-040 Clean codeword: start, then rows {0101,0101}, {1111,1111}, {0011,0011}, {1000,1000}, each row ending with in_last -> out_valid one cycle after the last beat, out_pass=1, out_fail_rows=0000, out_weight=0.
REQ-041 Errors: rows {0001}, {0000,0000}, {1100,0100}, {1111} -> out_pass=0, out_fail_rows=1101, out_weight=1+0+1+4=6.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle, busy=0.
REQ-043 Abort: start asserted again after 2 rows (first with syndrome 0011), then a clean codeword -> out_weight=0, out_pass=1.
REQ-044 Reset mid-ACCUM: rst for 1 cycle after 1 beat -> IDLE and all outputs 0; in_valid beats without start are never accepted.
REQ-045 Gaps: in_valid toggled 1,0,1 within a row -> only valid beats are XORed, and the result matches the gap-free run.
